// File: rtl/calc_pkg.sv
// Shared definitions for the calc_ops result path: app codes, word layout,
// requester indices and the output sequencer state encoding.
package calc_pkg;

  localparam int HDR_W     = 8;
  localparam int PAYLOAD_W = 40;
  localparam int WORD_W    = HDR_W + PAYLOAD_W;

  localparam logic [2:0] APP_ADD = 3'b001;
  localparam logic [2:0] APP_MUL = 3'b010;
  localparam logic [2:0] APP_SHF = 3'b011;

  localparam int         NUM_REQ = 3;
  localparam logic [1:0] REQ_ADD = 2'd0;
  localparam logic [1:0] REQ_MUL = 2'd1;
  localparam logic [1:0] REQ_SHF = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  function automatic logic [WORD_W-1:0] make_word(
    input logic [2:0]           app,
    input logic                 sel,
    input logic [2:0]           idx,
    input logic [PAYLOAD_W-1:0] payload
  );
    return {app, 1'b0, sel, idx, payload};
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// 3-way round-robin picker: grants the first asserted request found when
// searching upward from ptr, wrapping modulo 3.
module rr_arbiter3
  import calc_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt
);

  logic [2:0] cand [NUM_REQ];
  logic [2:0] hit;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_search
    logic [2:0] sum;
    assign sum      = {1'b0, ptr} + 3'(gi);
    assign cand[gi] = (sum >= 3'd3) ? sum - 3'd3 : sum;
    assign hit[gi]  = req[cand[gi][1:0]];
  end

  always_comb begin
    gnt = 3'b000;
    if (hit[0])      gnt = 3'b001 << cand[0];
    else if (hit[1]) gnt = 3'b001 << cand[1];
    else if (hit[2]) gnt = 3'b001 << cand[2];
  end

endmodule

// File: rtl/calc_result_arbiter.sv
// Round-robin arbiter and frame sequencer sharing the 48-bit result-write
// port between the ADD, MUL and SHIFT datapaths.
module calc_result_arbiter
  import calc_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [2:0]        req_valid,
  output logic [2:0]        req_ready,
  input  logic [2:0]        req_sel,
  input  logic [79:0]       add_c,
  input  logic [159:0]      mul_c,
  input  logic [79:0]       shf_c,
  input  logic              dout_full,
  output logic [WORD_W-1:0] dataout,
  output logic              wren,
  output logic              busy,
  output logic [1:0]        grant_id
);

  state_e            state_q;
  logic [1:0]        rr_ptr_q;
  logic [1:0]        grant_id_q;
  logic [1:0]        wcnt_q;
  logic [2:0]        gcnt_q;
  logic [2:0]        app_q;
  logic              sel_q;
  logic [159:0]      data_q;
  logic [WORD_W-1:0] dataout_q;
  logic              wren_q;
  logic              busy_q;

  logic [2:0]           gnt_d;
  logic [1:0]           win_d;
  logic [1:0]           last_wcnt_d;
  logic                 last_word_d;
  logic [2:0]           idx_d;
  logic [PAYLOAD_W-1:0] payload_d;
  logic [WORD_W-1:0]    word_d;

  rr_arbiter3 u_rr (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt_d)
  );

  always_comb begin
    win_d = REQ_ADD;
    if (gnt_d[REQ_MUL])      win_d = REQ_MUL;
    else if (gnt_d[REQ_SHF]) win_d = REQ_SHF;
  end

  assign req_ready = (state_q == ST_IDLE) ? gnt_d : 3'b000;

  // 2-word results sit in the low 80 bits of data_q, so the 40-bit segment
  // to send counts down from the frame's last word index.
  always_comb begin
    last_wcnt_d = (app_q == APP_MUL) ? 2'd3 : 2'd1;
    last_word_d = (wcnt_q == last_wcnt_d);
    idx_d       = (app_q == APP_MUL) ? {1'b0, wcnt_q} + 3'd1 : {1'b0, wcnt_q};
    case (last_wcnt_d - wcnt_q)
      2'd3:    payload_d = data_q[159:120];
      2'd2:    payload_d = data_q[119:80];
      2'd1:    payload_d = data_q[79:40];
      default: payload_d = data_q[39:0];
    endcase
    word_d = make_word(app_q, sel_q, idx_d, payload_d);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= 2'd0;
      grant_id_q <= 2'd0;
      wcnt_q     <= 2'd0;
      gcnt_q     <= 3'd0;
      app_q      <= APP_ADD;
      sel_q      <= 1'b0;
      data_q     <= '0;
      dataout_q  <= '0;
      wren_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      wren_q    <= 1'b0;
      dataout_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|gnt_d) begin
            grant_id_q <= win_d;
            rr_ptr_q   <= (win_d == REQ_SHF) ? REQ_ADD : win_d + 2'd1;
            wcnt_q     <= 2'd0;
            sel_q      <= req_sel[win_d];
            case (win_d)
              REQ_MUL: begin app_q <= APP_MUL; data_q <= mul_c;           end
              REQ_SHF: begin app_q <= APP_SHF; data_q <= {80'd0, shf_c}; end
              default: begin app_q <= APP_ADD; data_q <= {80'd0, add_c}; end
            endcase
            state_q <= ST_SEND;
            busy_q  <= 1'b1;
          end
        end
        ST_SEND: begin
          if (!dout_full) begin
            wren_q    <= 1'b1;
            dataout_q <= word_d;
            wcnt_q    <= wcnt_q + 2'd1;
            if (last_word_d) begin
              gcnt_q <= 3'd0;
              if (GAP_CYCLES > 0) begin
                state_q <= ST_GAP;
              end else begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
        end
        ST_GAP: begin
          if (gcnt_q == 3'(GAP_CYCLES - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gcnt_q <= gcnt_q + 3'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dataout  = dataout_q;
  assign wren     = wren_q;
  assign busy     = busy_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_calc_result_arbiter.sv
// Scoreboard bench for calc_result_arbiter: frames are predicted at grant time
// and checked word by word as the sequencer writes them out.
module tb_calc_result_arbiter;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [2:0]   req_valid = 3'b000;
  logic [2:0]   req_sel = 3'b000;
  logic [79:0]  add_c = '0;
  logic [159:0] mul_c = '0;
  logic [79:0]  shf_c = '0;
  logic         dout_full = 1'b0;

  logic [2:0]   req_ready, req_ready0;
  logic [47:0]  dataout, dataout0;
  logic         wren, wren0, busy, busy0;
  logic [1:0]   grant_id, grant_id0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [47:0] exp_q[$];
  logic [47:0] exp0_q[$];
  bit mon_en  = 1'b0;
  bit mon0_en = 1'b0;

  always #5 clk = ~clk;

  calc_result_arbiter #(.GAP_CYCLES(2)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .add_c(add_c), .mul_c(mul_c), .shf_c(shf_c),
    .dout_full(dout_full), .dataout(dataout), .wren(wren), .busy(busy),
    .grant_id(grant_id)
  );

  calc_result_arbiter #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready0),
    .req_sel(req_sel), .add_c(add_c), .mul_c(mul_c), .shf_c(shf_c),
    .dout_full(dout_full), .dataout(dataout0), .wren(wren0), .busy(busy0),
    .grant_id(grant_id0)
  );

  always @(negedge clk) begin : mon
    logic [47:0] e;
    if (mon_en) begin
      n_checks++;
      if (wren === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL word_unexpected: dataout=%h written with nothing expected", dataout);
        end else begin
          e = exp_q.pop_front();
          if (dataout !== e) begin
            n_fail++;
            $display("FAIL word_data: dataout=%h expected %h", dataout, e);
          end
        end
      end else if (wren !== 1'b0 || dataout !== 48'h0) begin
        n_fail++;
        $display("FAIL idle_output: wren=%b dataout=%h expected wren=0 dataout=0", wren, dataout);
      end
    end
  end

  always @(negedge clk) begin : mon0
    logic [47:0] e;
    if (mon0_en) begin
      n_checks++;
      if (wren0 === 1'b1) begin
        if (exp0_q.size() == 0) begin
          n_fail++;
          $display("FAIL gap0_word_unexpected: dataout=%h written with nothing expected", dataout0);
        end else begin
          e = exp0_q.pop_front();
          if (dataout0 !== e) begin
            n_fail++;
            $display("FAIL gap0_word_data: dataout=%h expected %h", dataout0, e);
          end
        end
      end else if (wren0 !== 1'b0 || dataout0 !== 48'h0) begin
        n_fail++;
        $display("FAIL gap0_idle_output: wren=%b dataout=%h expected 0/0", wren0, dataout0);
      end
    end
  end

  function automatic logic [47:0] w(input logic [2:0] app, input logic sel,
                                    input logic [2:0] idx, input logic [39:0] p);
    return {app, 1'b0, sel, idx, p};
  endfunction

  function automatic logic [79:0] rand80();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[79:0];
  endfunction

  function automatic logic [159:0] rand160();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Requester r: 0 ADD, 1 MUL, 2 SHIFT. which selects the scoreboard.
  task automatic push_frame(input int which, input int r, input logic sel, input logic [159:0] c);
    logic [47:0] ws[$];
    case (r)
      0: begin
        ws.push_back(w(3'b001, sel, 3'd0, c[79:40]));
        ws.push_back(w(3'b001, sel, 3'd1, c[39:0]));
      end
      1: begin
        ws.push_back(w(3'b010, sel, 3'd1, c[159:120]));
        ws.push_back(w(3'b010, sel, 3'd2, c[119:80]));
        ws.push_back(w(3'b010, sel, 3'd3, c[79:40]));
        ws.push_back(w(3'b010, sel, 3'd4, c[39:0]));
      end
      default: begin
        ws.push_back(w(3'b011, sel, 3'd0, c[79:40]));
        ws.push_back(w(3'b011, sel, 3'd1, c[39:0]));
      end
    endcase
    foreach (ws[i]) begin
      if (which == 0) exp_q.push_back(ws[i]);
      else            exp0_q.push_back(ws[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (dataout !== 48'h0) begin n_fail++; $display("FAIL reset_dataout: got %h expected 0", dataout); end
    n_checks++; if (wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %b expected 0", wren); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
    n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready: got %b expected 000", req_ready); end
    #1 rstn = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || req_ready !== 3'b000) begin
      n_fail++; $display("FAIL post_reset_idle: busy=%b ready=%b expected 0/000", busy, req_ready);
    end
    mon_en = 1'b1;
    $display("reset: outputs cleared, idle after release");
  endtask

  task automatic test_add();
    logic [79:0] c = 80'h0123456789_ABCDEF0123;
    logic wren_pat [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic busy_pat [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tick();
    push_frame(0, 0, 1'b1, {80'd0, c});
    add_c = c; req_sel = 3'b001; req_valid = 3'b001;
    @(negedge clk);
    n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL add_ready: got %b expected 001", req_ready); end
    tick();
    req_valid = 3'b000; add_c = ~c;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if (wren !== wren_pat[k]) begin n_fail++; $display("FAIL add_wren_T%0d: got %b expected %b", k + 1, wren, wren_pat[k]); end
      n_checks++; if (busy !== busy_pat[k]) begin n_fail++; $display("FAIL add_busy_T%0d: got %b expected %b", k + 1, busy, busy_pat[k]); end
    end
    n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL add_grant_id: got %0d expected 0", grant_id); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL add_drain: %0d words left expected 0", exp_q.size()); end
    $display("add: 2-word frame 28/29 at T+2..T+3, 2 gap cycles");
  endtask

  task automatic test_mul();
    logic [159:0] c = 160'h1111111111_2222222222_3333333333_4444444444;
    logic wren_pat [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic busy_pat [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tick();
    push_frame(0, 1, 1'b0, c);
    mul_c = c; req_sel = 3'b000; req_valid = 3'b010;
    @(negedge clk);
    n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL mul_ready: got %b expected 010", req_ready); end
    tick();
    req_valid = 3'b000; mul_c = rand160();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      n_checks++; if (wren !== wren_pat[k]) begin n_fail++; $display("FAIL mul_wren_T%0d: got %b expected %b", k + 1, wren, wren_pat[k]); end
      n_checks++; if (busy !== busy_pat[k]) begin n_fail++; $display("FAIL mul_busy_T%0d: got %b expected %b", k + 1, busy, busy_pat[k]); end
    end
    n_checks++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL mul_grant_id: got %0d expected 1", grant_id); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mul_drain: %0d words left expected 0", exp_q.size()); end
    $display("mul: 4-word frame 41..44 in order");
  endtask

  task automatic test_round_robin();
    int exp_order [6] = '{0, 1, 2, 0, 1, 2};
    int ng = 0;
    int budget = 0;
    int r;
    logic [159:0] c;
    tick(); rstn = 1'b0; tick(); rstn = 1'b1;
    add_c = rand80(); mul_c = rand160(); shf_c = rand80();
    req_sel = 3'b101; req_valid = 3'b111;
    while (ng < 6 && budget < 200) begin
      @(negedge clk); budget++;
      if (req_ready !== 3'b000) begin
        r = exp_order[ng];
        n_checks++; if (req_ready !== (3'b001 << r)) begin
          n_fail++; $display("FAIL rr_order_%0d: ready=%b expected %b", ng, req_ready, 3'b001 << r);
        end
        c = (r == 1) ? mul_c : (r == 0) ? {80'd0, add_c} : {80'd0, shf_c};
        push_frame(0, r, req_sel[r], c);
        ng++;
        tick();
        if (r == 0) add_c = rand80(); else if (r == 1) mul_c = rand160(); else shf_c = rand80();
        @(negedge clk); budget++;
        n_checks++; if (grant_id !== 2'(r)) begin n_fail++; $display("FAIL rr_grant_id_%0d: got %0d expected %0d", ng - 1, grant_id, r); end
        $display("rr: grant %0d to requester %0d", ng - 1, r);
      end
    end
    n_checks++; if (ng != 6) begin n_fail++; $display("FAIL rr_timeout: %0d grants seen expected 6", ng); end
    req_valid = 3'b000;
    for (int k = 0; k < 50 && (exp_q.size() != 0 || busy === 1'b1); k++) @(negedge clk);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rr_drain: %0d words left expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [159:0] c;
    logic wren_pat [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tick();
    c = rand160();
    push_frame(0, 1, 1'b1, c);
    mul_c = c; req_sel = 3'b010; req_valid = 3'b010;
    @(negedge clk);
    n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL bp_ready: got %b expected 010", req_ready); end
    tick();
    req_valid = 3'b000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++; if (wren !== wren_pat[k]) begin n_fail++; $display("FAIL bp_wren_T%0d: got %b expected %b", k + 1, wren, wren_pat[k]); end
      if (k == 0) begin tick(); dout_full = 1'b1; end
      if (k == 3) begin tick(); dout_full = 1'b0; end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain: %0d words left expected 0", exp_q.size()); end
    $display("backpressure: 3 stall cycles after first MUL word");
  endtask

  task automatic test_reset_mid();
    logic [159:0] c;
    tick();
    c = rand160();
    push_frame(0, 1, 1'b0, c);
    mul_c = c; req_sel = 3'b000; req_valid = 3'b010;
    @(negedge clk);
    n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 010", req_ready); end
    tick();
    req_valid = 3'b000;
    repeat (3) @(negedge clk);
    n_checks++; if (wren !== 1'b1) begin n_fail++; $display("FAIL rstmid_word2: wren=%b expected 1", wren); end
    #1 rstn = 1'b0;
    #1;
    n_checks++; if (wren !== 1'b0 || dataout !== 48'h0) begin
      n_fail++; $display("FAIL rstmid_abort: wren=%b dataout=%h expected 0/0", wren, dataout);
    end
    exp_q.delete();
    @(posedge clk);
    #3 rstn = 1'b1;
    @(negedge clk);
    n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rstmid_grant_id: got %0d expected 0", grant_id); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    #1 req_valid = 3'b010;
    #1;
    n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL rstmid_idle: ready=%b expected 010", req_ready); end
    req_valid = 3'b000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++; if (wren !== 1'b0) begin n_fail++; $display("FAIL rstmid_resume_%0d: wren=%b expected 0", k, wren); end
    end
    $display("reset_mid: frame aborted, no resume");
  endtask

  task automatic test_gap0();
    int cyc = 0;
    int ng = 0;
    int last_g = 0;
    mon_en = 1'b0;
    tick(); rstn = 1'b0; tick(); rstn = 1'b1;
    mon0_en = 1'b1;
    add_c = rand80(); req_sel = 3'b001; req_valid = 3'b001;
    while (ng < 4 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (req_ready0 !== 3'b000) begin
        push_frame(1, 0, 1'b1, {80'd0, add_c});
        if (ng > 0) begin
          n_checks++; if (cyc - last_g != 3) begin
            n_fail++; $display("FAIL gap0_spacing_%0d: got %0d cycles expected 3", ng, cyc - last_g);
          end
        end
        $display("gap0: grant %0d at cycle %0d", ng, cyc);
        last_g = cyc;
        ng++;
        tick();
        add_c = rand80();
      end
    end
    n_checks++; if (ng != 4) begin n_fail++; $display("FAIL gap0_timeout: %0d grants seen expected 4", ng); end
    req_valid = 3'b000;
    for (int k = 0; k < 20 && exp0_q.size() != 0; k++) @(negedge clk);
    n_checks++; if (exp0_q.size() != 0) begin n_fail++; $display("FAIL gap0_drain: %0d words left expected 0", exp0_q.size()); end
    mon0_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_gap0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
